mux_4_1_scan_ctrl: RTL and testbench
====================================

Name: mux_4_1_scan_ctrl

Overview:
- Upstream sequencer and downstream sampler for the 4:1 transmission-gate mux (`mux_4_1_tran`).
- Drives the mux select lines `s1`/`s0` through channels a, b, c, d in order.
- For each channel, waits a programmable settle time, then samples the mux output `y`.
- After all four channels, presents the four sampled bits as one word on a valid/ready handshake.

Parameters:
- SETTLE_CYC, 2, number of cycles select is held stable before `y` is sampled; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, width of the internal settle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- y  input  1  mux output being scanned.
- s0  output  1  mux select LSB.
- s1  output  1  mux select MSB.
- busy  output  1  high in any state other than IDLE.
- word  output  4  sampled bits; bit0=a, bit1=b, bit2=c, bit3=d.
- valid  output  1  `word` is available.
- ready  input  1  consumer accepts `word`.

Behaviour:
- Reset: async assert on `rst_n`=0, synchronous release.
  - All outputs cleared: `s0`=0, `s1`=0, `busy`=0, `valid`=0, `word`=4'b0000.
  - State forced to IDLE; channel index = 0; settle counter = 0; shadow word cleared.
- Select mapping: {`s1`,`s0`} = channel index: a=00, b=01, c=10, d=11. `s0`/`s1` are registered.
- States:
  - IDLE
    - Select = 00.
    - On `start`=1: go to SETTLE, channel index = 0, counter = SETTLE_CYC-1.
  - SETTLE
    - Select = channel index; counter decrements each cycle.
    - When counter = 0: go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYC cycles.
  - SAMPLE (one cycle)
    - Capture `y` into shadow bit [channel index].
    - If channel index < 3: increment channel index, counter = SETTLE_CYC-1, go to SETTLE. The new select appears on the next cycle.
    - If channel index = 3: copy the shadow word, including the bit captured this cycle, to `word`; set `valid`=1; go to HOLD.
  - HOLD
    - `word` and `valid` stay stable; select stays 11.
    - On `valid`&&`ready`: `valid`=0 on the next edge.
    - If `start`=1 in the same cycle: go directly to SETTLE with channel index 0 (back-to-back scan).
    - Otherwise: go to IDLE.
- Latency: the first valid cycle is exactly 4*(SETTLE_CYC+1)+1 cycles after the clock edge that sampled `start`; 13 cycles at default.
- `word` updates only on entry to HOLD. It holds its last value through IDLE and through the next scan until the next HOLD entry.
- `start` while `busy`=1 is ignored, except in the HOLD handshake cycle described above.
- `ready` outside HOLD is ignored. `ready` held high on entry to HOLD completes the transfer in the first valid cycle.
- Changes on `y` outside SAMPLE cycles have no effect.
- Reset mid-scan: abandon the scan, apply the reset values above, and drop any partial shadow word.

Optional Feature:
- Macro `MUX_SCAN_PARITY_EN`.
- When defined:
  - Adds output port `parity` (1 bit) = XOR of the four bits written to `word`.
  - `parity` is registered on the same edge as `word`, so it is always consistent with it.
  - Reset value of `parity` is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert `rst_n`=0 mid-cycle without a clock edge -> `s0`=`s1`=`busy`=`valid`=0 and `word`=0000 immediately.
- Single scan, SETTLE_CYC=2:
  - Stimulus: behavioural mux model with a=0, b=1, c=0, d=1 driving `y`; pulse `start`; `ready`=1.
  - Expected select sequence: 00, 01, 10, 11, each held 3 cycles.
  - Expected result: `valid` high 13 cycles after `start` with `word`=1010 for exactly 1 cycle, then `busy`=0.
- Backpressure:
  - Stimulus: a=1, b=1, c=0, d=0; `ready`=0 for 5 cycles after `valid`, toggling a..d during that time.
  - Expected: `word`=0011 and `valid`=1 held unchanged; transfer completes on the cycle `ready` goes high.
- Start while busy: pulse `start` during SETTLE of channel c -> no restart; one `valid` only, at cycle 13.
- Reset mid-scan: drop `rst_n` during SAMPLE of channel b -> outputs return to reset values. A fresh `start` then produces the correct full word with no stale bits.
- Back-to-back: hold `start`=1 and `ready`=1 continuously -> `valid` pulses every 13 cycles; `busy` never drops. With `MUX_SCAN_PARITY_EN`, word=1010 gives `parity`=0 and word=0111 gives `parity`=1.

Source files
------------

// File: rtl/mux_4_1_scan_ctrl.sv
// mux_4_1_scan_ctrl: walks the 4:1 mux select through channels a..d,
// waits SETTLE_CYC cycles on each, samples y, then offers the 4-bit
// result on a valid/ready handshake.
// Optional macro MUX_SCAN_PARITY_EN adds a registered even-parity output.
module mux_4_1_scan_ctrl #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y,
   output logic       s0,
   output logic       s1,
   output logic       busy,
   output logic [3:0] word,
   output logic       valid,
`ifdef MUX_SCAN_PARITY_EN
   output logic       parity,
`endif
   input  logic       ready
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

   state_t           state, state_nxt;
   logic [1:0]       ch, ch_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       shadow, shadow_nxt;
   logic [3:0]       word_nxt;
   logic             valid_nxt;
   logic [1:0]       sel, sel_nxt;

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ch     <= '0;
         cnt    <= '0;
         shadow <= '0;
         word   <= '0;
         valid  <= 1'b0;
         sel    <= '0;
      end else begin
         state  <= state_nxt;
         ch     <= ch_nxt;
         cnt    <= cnt_nxt;
         shadow <= shadow_nxt;
         word   <= word_nxt;
         valid  <= valid_nxt;
         sel    <= sel_nxt;
      end
   end

   // Next-state and next-output logic; select is computed one cycle
   // ahead so the registered s1/s0 line up with the channel index
   always_comb begin
      state_nxt  = state;
      ch_nxt     = ch;
      cnt_nxt    = cnt;
      shadow_nxt = shadow;
      word_nxt   = word;
      valid_nxt  = valid;
      sel_nxt    = sel;
      case (state)
         IDLE: begin
            sel_nxt = '0;
            if (start) begin
               state_nxt = SETTLE;
               ch_nxt    = '0;
               cnt_nxt   = CNT_LOAD;
            end
         end
         SETTLE: begin
            sel_nxt = ch;
            if (cnt == '0) begin
               state_nxt = SAMPLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         SAMPLE: begin
            shadow_nxt[ch] = y;
            if (ch != 2'd3) begin
               ch_nxt    = ch + 2'd1;
               cnt_nxt   = CNT_LOAD;
               sel_nxt   = ch + 2'd1;
               state_nxt = SETTLE;
            end else begin
               word_nxt  = {y, shadow[2:0]};
               valid_nxt = 1'b1;
               sel_nxt   = 2'b11;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            sel_nxt = 2'b11;
            if (valid && ready) begin
               valid_nxt = 1'b0;
               sel_nxt   = '0;
               if (start) begin
                  state_nxt = SETTLE;
                  ch_nxt    = '0;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef MUX_SCAN_PARITY_EN
   // Parity follows word on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity <= 1'b0;
      end else begin
         parity <= ^word_nxt;
      end
   end
`endif

   assign s1   = sel[1];
   assign s0   = sel[0];
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_4_1_scan_ctrl.sv
// Bench for mux_4_1_scan_ctrl: behavioural 4:1 mux on y, randomized
// channel data, expected words derived from the scan timing rules.
module tb_mux_4_1_scan_ctrl;

   localparam int unsigned S   = 2;
   localparam int unsigned PER = S + 1;
   localparam int unsigned LAT = 4 * PER + 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       y;
   logic       s0, s1, busy, valid, ready;
   logic [3:0] word;
   logic [3:0] data;
`ifdef MUX_SCAN_PARITY_EN
   logic       parity;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   // behavioural transmission-gate mux: data[k] is channel k (a=0..d=3)
   assign y = data[{s1, s0}];

   mux_4_1_scan_ctrl #(.SETTLE_CYC(S), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .y     (y),
      .s0    (s0),
      .s1    (s1),
      .busy  (busy),
      .word  (word),
      .valid (valid),
`ifdef MUX_SCAN_PARITY_EN
      .parity(parity),
`endif
      .ready (ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset;
      check("rst_s0", s0, 0);
      check("rst_s1", s1, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_word", word, 0);
`ifdef MUX_SCAN_PARITY_EN
      check("rst_parity", parity, 0);
`endif
   endtask

   // One scan from IDLE. Channel k is sampled at the edge ending cycle
   // (k+1)*PER-1 after the start edge; select in cycle n is n/PER.
   task automatic scan(input logic [3:0] pat, input bit rand_y,
                       input int unsigned stall, input int busy_start);
      logic [3:0] exp_word;
      int         lat;
      int         k;
      data     = pat;
      ready    = (stall == 0);
      start    = 1'b1;
      tick;
      start    = 1'b0;
      exp_word = '0;
      lat      = 0;
      for (int n = 0; n < 40; n++) begin
         if (valid) begin
            lat = n + 1;
            break;
         end
         check("sel", {s1, s0}, ((n / PER) > 3) ? 3 : (n / PER));
         check("busy", busy, 1);
         start = (n == busy_start);
         if (rand_y) data = 4'($urandom);
         k = (n + 1) / PER;
         if (((n + 1) % PER == 0) && k >= 1 && k <= 4) exp_word[k-1] = data[k-1];
         tick;
      end
      start = 1'b0;
      check("latency", lat, LAT);
      check("word", word, exp_word);
      check("valid_sel", {s1, s0}, 3);
`ifdef MUX_SCAN_PARITY_EN
      check("parity", parity, ^exp_word);
`endif
      for (int i = 1; i < int'(stall); i++) begin
         data = 4'($urandom);
         tick;
         check("hold_valid", valid, 1);
         check("hold_word", word, exp_word);
      end
      ready = 1'b1;
      tick;
      check("valid_drop", valid, 0);
      check("idle_busy", busy, 0);
      check("idle_sel", {s1, s0}, 0);
      check("word_keep", word, exp_word);
      ready = 1'b0;
   endtask

   // start and ready held high: a new scan every LAT cycles, never idle
   task automatic back_to_back;
      logic [3:0] pats [3];
      int         lat;
      pats[0] = 4'b1010;
      pats[1] = 4'b0111;
      pats[2] = 4'($urandom);
      ready   = 1'b1;
      start   = 1'b1;
      data    = pats[0];
      tick;
      for (int j = 0; j < 3; j++) begin
         lat = 0;
         for (int n = 0; n < 40; n++) begin
            if (valid) begin
               lat = n + 1;
               break;
            end
            check("b2b_busy", busy, 1);
            tick;
         end
         check("b2b_latency", lat, LAT);
         check("b2b_word", word, pats[j]);
`ifdef MUX_SCAN_PARITY_EN
         check("b2b_parity", parity, ^pats[j]);
`endif
         if (j < 2) data = pats[j+1];
         else start = 1'b0;
         tick;
         check("b2b_valid_drop", valid, 0);
         check("b2b_busy_next", busy, (j < 2) ? 1 : 0);
      end
      ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      data  = '0;
      #1 rst_n = 1'b0;
      #1 check_reset;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick;

      // a=0 b=1 c=0 d=1, ready high throughout
      scan(4'b1010, 1'b0, 0, -1);
      // a=1 b=1 c=0 d=0 with 5 cycles of backpressure
      scan(4'b0011, 1'b0, 5, -1);
      // start pulsed during channel c settle is ignored
      scan(4'($urandom), 1'b1, 0, 2 * PER + 1);
      for (int i = 0; i < 15; i++) begin
         check("no_restart_valid", valid, 0);
         check("no_restart_busy", busy, 0);
         tick;
      end
      // random channel data and random backpressure
      for (int i = 0; i < 4; i++) begin
         scan(4'($urandom), 1'b1, $urandom_range(0, 3), -1);
      end

      // reset during SAMPLE of channel b
      data  = 4'b1111;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (2 * PER - 1) tick;
      check("pre_reset_sel", {s1, s0}, 1);
      #2 rst_n = 1'b0;
      #1 check_reset;
      tick;
      rst_n = 1'b1;
      tick;
      check_reset;
      scan(4'b0100, 1'b0, 0, -1);

      back_to_back;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
